// File: rtl/mult_arbiter.sv
// mult_arbiter: two-requester round-robin front end for one shared
// sequential 16x16 multiplier. A request is captured in IDLE, issued with a
// one-cycle start pulse, waited on with a bounded cycle counter, and answered
// with a one-cycle response pulse on the served requester's rsp_valid.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no operation; arbitrate req0/req1 and capture the winner
// S_ISSUE | one cycle: mul_start and the winner's ack
// S_WAIT  | operands on mul_A/mul_B; wait for mul_done or the timeout
// S_RESP  | one cycle: rsp_valid of the served requester, result/error
//
// Every output is decoded from the state register plus registered data, so
// the asynchronous reset clears all outputs without waiting for a clock.

module mult_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  output logic [31:0] rsp_res,
  output logic        rsp_err,
  output logic [15:0] mul_A,
  output logic [15:0] mul_B,
  output logic        mul_start,
  input  logic [31:0] mul_res,
  input  logic        mul_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Last WAIT count value before the request is given up.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_id;
  logic        r_last;
  logic [7:0]  r_cnt;
  logic [31:0] r_res;
  logic        r_err;

  logic        w_req_any;
  logic        w_grant;
  logic        w_tmo;

  assign w_req_any = req0 | req1;
  // On a tie the requester not served last wins; otherwise the only requester.
  assign w_grant   = (req0 & req1) ? ~r_last : req1;
  assign w_tmo     = (r_cnt == LP_CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; mul_done is only looked at in WAIT and wins over timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (mul_done || w_tmo) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, WAIT counter, result capture and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
      r_cnt  <= '0;
      r_res  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_id <= w_grant;
            r_a  <= w_grant ? a1 : a0;
            r_b  <= w_grant ? b1 : b0;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (mul_done) begin
            r_res <= mul_res;
            r_err <= 1'b0;
          end else if (w_tmo) begin
            r_res <= '0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_last <= r_id;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and registered data only.
  always_comb begin
    ack0       = 1'b0;
    ack1       = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    rsp_res    = '0;
    rsp_err    = 1'b0;
    mul_A      = '0;
    mul_B      = '0;
    mul_start  = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_ISSUE: begin
        mul_start = 1'b1;
        ack0      = ~r_id;
        ack1      = r_id;
        mul_A     = r_a;
        mul_B     = r_b;
      end
      S_WAIT: begin
        mul_A = r_a;
        mul_B = r_b;
      end
      S_RESP: begin
        rsp_valid0 = ~r_id;
        rsp_valid1 = r_id;
        rsp_res    = r_res;
        rsp_err    = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: two instances share the request side, one with the
// default timeout (_m) and one with TIMEOUT=16 (_t). Each has its own
// multiplier model; expected responses are queued when a request is driven
// and popped when the instance pulses rsp_valid.

module tb_mult_arbiter;

  localparam int TO_M = 255;
  localparam int TO_T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;

  logic        ack0_m, ack1_m, rv0_m, rv1_m, err_m, start_m, busy_m, done_m;
  logic [31:0] res_m, mres_m;
  logic [15:0] ma_m, mb_m;

  logic        ack0_t, ack1_t, rv0_t, rv1_t, err_t, start_t, busy_t, done_mdl_t, done_t;
  logic [31:0] res_t, mres_t;
  logic [15:0] ma_t, mb_t;
  logic        force_t;

  assign done_t = done_mdl_t | force_t;

  mult_arbiter #(.TIMEOUT(TO_M)) u_dut_m (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0_m), .ack1(ack1_m), .rsp_valid0(rv0_m), .rsp_valid1(rv1_m),
    .rsp_res(res_m), .rsp_err(err_m), .mul_A(ma_m), .mul_B(mb_m),
    .mul_start(start_m), .mul_res(mres_m), .mul_done(done_m), .busy(busy_m)
  );

  mult_arbiter #(.TIMEOUT(TO_T)) u_dut_t (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0_t), .ack1(ack1_t), .rsp_valid0(rv0_t), .rsp_valid1(rv1_t),
    .rsp_res(res_t), .rsp_err(err_t), .mul_A(ma_t), .mul_B(mb_t),
    .mul_start(start_t), .mul_res(mres_t), .mul_done(done_t), .busy(busy_t)
  );

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        err;
  } rsp_t;

  rsp_t q_m[$];
  rsp_t q_t[$];
  rsp_t e_m, e_t;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat_m, lat_t;
  int   cnt_m, cnt_t;
  logic [31:0] hold_m, hold_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected response: done arrives lat cycles into WAIT; lat=0 means never.
  function automatic rsp_t model(input logic id, input logic [15:0] a, input logic [15:0] b,
                                 input int lat, input int to);
    rsp_t r;
    r.id = id;
    if (lat >= 1 && lat <= to - 1) begin
      r.res = 32'(a) * 32'(b);
      r.err = 1'b0;
    end else begin
      r.res = '0;
      r.err = 1'b1;
    end
    return r;
  endfunction

  task automatic expect_rsp(input logic id, input logic [15:0] a, input logic [15:0] b);
    q_m.push_back(model(id, a, b, lat_m, TO_M));
    q_t.push_back(model(id, a, b, lat_t, TO_T));
  endtask

  // Multiplier model for the default-timeout instance.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_m  <= 0;
      done_m <= 1'b0;
      mres_m <= '0;
      hold_m <= '0;
    end else begin
      done_m <= 1'b0;
      if (start_m) begin
        cnt_m  <= lat_m;
        hold_m <= 32'(ma_m) * 32'(mb_m);
      end else if (cnt_m != 0) begin
        cnt_m <= cnt_m - 1;
        if (cnt_m == 1) begin
          done_m <= 1'b1;
          mres_m <= hold_m;
        end
      end
    end
  end

  // Multiplier model for the short-timeout instance.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_t      <= 0;
      done_mdl_t <= 1'b0;
      mres_t     <= '0;
      hold_t     <= '0;
    end else begin
      done_mdl_t <= 1'b0;
      if (start_t) begin
        cnt_t  <= lat_t;
        hold_t <= 32'(ma_t) * 32'(mb_t);
      end else if (cnt_t != 0) begin
        cnt_t <= cnt_t - 1;
        if (cnt_t == 1) begin
          done_mdl_t <= 1'b1;
          mres_t     <= hold_t;
        end
      end
    end
  end

  // Response monitors: pop the scoreboard on every rsp_valid pulse.
  always @(negedge clk) begin
    if (reset === 1'b1 && (rv0_m || rv1_m)) begin
      if (q_m.size() == 0) begin
        chk("m_unexpected_rsp", 32'({rv1_m, rv0_m}), 32'd0);
      end else begin
        e_m = q_m.pop_front();
        chk("m_rsp_sel", 32'({rv1_m, rv0_m}), e_m.id ? 32'd2 : 32'd1);
        chk("m_rsp_res", res_m, e_m.res);
        chk("m_rsp_err", 32'(err_m), 32'(e_m.err));
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && (rv0_t || rv1_t)) begin
      if (q_t.size() == 0) begin
        chk("t_unexpected_rsp", 32'({rv1_t, rv0_t}), 32'd0);
      end else begin
        e_t = q_t.pop_front();
        chk("t_rsp_sel", 32'({rv1_t, rv0_t}), e_t.id ? 32'd2 : 32'd1);
        chk("t_rsp_res", res_t, e_t.res);
        chk("t_rsp_err", 32'(err_t), 32'(e_t.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy_m || busy_t); i++) tick();
    chk("idle_reached", 32'({busy_t, busy_m}), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl_m"}, 32'({ack0_m, ack1_m, rv0_m, rv1_m, err_m, start_m, busy_m}), 32'd0);
    chk({tag, "_dat_m"}, res_m | 32'(ma_m) | 32'(mb_m), 32'd0);
    chk({tag, "_ctl_t"}, 32'({ack0_t, ack1_t, rv0_t, rv1_t, err_t, start_t, busy_t}), 32'd0);
    chk({tag, "_dat_t"}, res_t | 32'(ma_t) | 32'(mb_t), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q_m.delete();
    q_t.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset   = 1'b0;
    req0    = 1'b0;
    req1    = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    force_t = 1'b0;
    lat_m   = 17;
    lat_t   = 17;
    #2;
    check_all_zero("reset");
    do_reset();

    // Single request from requester 0, done 17 cycles into WAIT.
    a0 = 16'd18; b0 = 16'd24; req0 = 1'b1;
    expect_rsp(1'b0, 16'd18, 16'd24);
    tick();
    chk("single_ack", 32'({ack1_m, ack0_m, start_m}), 32'b011);
    chk("single_opA", 32'(ma_m), 32'd18);
    chk("single_opB", 32'(mb_m), 32'd24);
    req0 = 1'b0;
    tick();
    chk("single_pulse_end", 32'({ack0_m, start_m, busy_m}), 32'b001);
    n = 1;
    while (!rv0_m && n < 40) begin
      tick();
      n++;
    end
    chk("single_latency", 32'(n), 32'd19);
    tick();
    chk("single_back_idle", 32'(busy_m), 32'd0);
    wait_idle(40);

    // Tie from reset: 0 first, then 1; the next tie serves 0 first again.
    do_reset();
    lat_m = 5; lat_t = 5;
    a0 = 16'd3; b0 = 16'd8; a1 = 16'd7; b1 = 16'd6;
    req0 = 1'b1; req1 = 1'b1;
    expect_rsp(1'b0, 16'd3, 16'd8);
    expect_rsp(1'b1, 16'd7, 16'd6);
    tick();
    chk("tie1_first", 32'({ack1_m, ack0_m}), 32'b01);
    req0 = 1'b0;
    for (int i = 0; i < 40 && !ack1_m; i++) tick();
    chk("tie1_second", 32'({ack1_m, ack0_m}), 32'b10);
    req1 = 1'b0;
    wait_idle(40);
    a0 = 16'd100; b0 = 16'd200; a1 = 16'd300; b1 = 16'd5;
    req0 = 1'b1; req1 = 1'b1;
    expect_rsp(1'b0, 16'd100, 16'd200);
    expect_rsp(1'b1, 16'd300, 16'd5);
    tick();
    chk("tie2_first", 32'({ack1_m, ack0_m}), 32'b01);
    req0 = 1'b0;
    for (int i = 0; i < 40 && !ack1_m; i++) tick();
    chk("tie2_second", 32'({ack1_m, ack0_m}), 32'b10);
    req1 = 1'b0;
    wait_idle(40);

    // Timeout: multiplier never answers; late done in IDLE is ignored.
    lat_m = 0; lat_t = 0;
    a0 = 16'd5; b0 = 16'd9; req0 = 1'b1;
    expect_rsp(1'b0, 16'd5, 16'd9);
    tick();
    req0 = 1'b0;
    n = 0;
    while (!rv0_t && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'd17);
    tick();
    chk("timeout_idle", 32'(busy_t), 32'd0);
    force_t = 1'b1;
    tick();
    force_t = 1'b0;
    chk("late_done_idle", 32'({busy_t, rv0_t, rv1_t}), 32'd0);
    tick();
    chk("late_done_after", 32'({busy_t, rv0_t, rv1_t}), 32'd0);
    wait_idle(400);

    // Largest operands.
    lat_m = 3; lat_t = 3;
    a0 = 16'hFFFF; b0 = 16'hFFFF; req0 = 1'b1;
    expect_rsp(1'b0, 16'hFFFF, 16'hFFFF);
    tick();
    chk("max_opA", 32'(ma_t), 32'h0000_FFFF);
    req0 = 1'b0;
    wait_idle(40);

    // Done on the last WAIT cycle wins; one cycle later it is a timeout.
    lat_m = 15; lat_t = 15;
    a1 = 16'd1234; b1 = 16'd5678; req1 = 1'b1;
    expect_rsp(1'b1, 16'd1234, 16'd5678);
    tick();
    req1 = 1'b0;
    wait_idle(40);
    lat_m = 16; lat_t = 16;
    a1 = 16'd77; b1 = 16'd91; req1 = 1'b1;
    expect_rsp(1'b1, 16'd77, 16'd91);
    tick();
    req1 = 1'b0;
    wait_idle(40);

    // Reset in the middle of WAIT: no response, then a clean request.
    lat_m = 0; lat_t = 0;
    a0 = 16'd9; b0 = 16'd9; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (5) tick();
    chk("midwait_busy", 32'({busy_t, busy_m}), 32'b11);
    reset = 1'b0;
    q_m.delete();
    q_t.delete();
    #1;
    check_all_zero("midwait_reset");
    tick();
    tick();
    reset = 1'b1;
    lat_m = 4; lat_t = 4;
    a1 = 16'd2; b1 = 16'd3; req1 = 1'b1;
    expect_rsp(1'b1, 16'd2, 16'd3);
    tick();
    chk("post_reset_ack1", 32'({ack1_m, ack0_m}), 32'b10);
    req1 = 1'b0;
    wait_idle(40);

    // Operands changed after ack must not reach the multiplier.
    lat_m = 6; lat_t = 6;
    a0 = 16'd11; b0 = 16'd13; req0 = 1'b1;
    expect_rsp(1'b0, 16'd11, 16'd13);
    tick();
    req0 = 1'b0;
    a0 = 16'd500; b0 = 16'd600;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_opA", 32'(ma_m), 32'd11);
      chk("hold_opB", 32'(mb_m), 32'd13);
    end
    wait_idle(40);

    tick();
    chk("queue_m_empty", 32'(q_m.size()), 32'd0);
    chk("queue_t_empty", 32'(q_t.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
